// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester, response and shared-ALU signals of the ALU arbiter
interface alu_arbiter_if #(
  parameter int WORD_SIZE = 9,
  parameter int NUM_REQ   = 4
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*WORD_SIZE-1:0] req_a;
  logic [NUM_REQ*WORD_SIZE-1:0] req_b;
  logic [NUM_REQ-1:0]           req_op;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [NUM_REQ-1:0]           rsp_ready;
  logic [WORD_SIZE-1:0]         rsp_data;
  logic [WORD_SIZE-1:0]         alu_a;
  logic [WORD_SIZE-1:0]         alu_b;
  logic                         alu_op;
  logic [WORD_SIZE-1:0]         alu_c;
  logic                         busy;

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready, alu_c,
    output req_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_op, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready, alu_c,
    input  req_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_op, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sequencer sharing one add/sub ALU among NUM_REQ requesters
module alu_arbiter #(
  parameter int WORD_SIZE = 9,
  parameter int NUM_REQ   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);
  localparam int GRANT_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [GRANT_W-1:0]   r_last_grant;
  logic [GRANT_W-1:0]   r_owner;
  logic [WORD_SIZE-1:0] r_a;
  logic [WORD_SIZE-1:0] r_b;
  logic                 r_op;
  logic [WORD_SIZE-1:0] r_result;

  logic                 w_found;
  logic [GRANT_W-1:0]   w_grant;
  logic [GRANT_W-1:0]   w_cand;
  logic                 w_accept;
  logic [WORD_SIZE-1:0] w_a_arr [NUM_REQ];
  logic [WORD_SIZE-1:0] w_b_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_a_arr[gi] = bus.req_a[gi*WORD_SIZE +: WORD_SIZE];
    assign w_b_arr[gi] = bus.req_b[gi*WORD_SIZE +: WORD_SIZE];
  end

  // First valid requester after the previous owner, wrapping at NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = GRANT_W'((int'(r_last_grant) + k) % NUM_REQ);
      if (!w_found && bus.req_valid[w_cand]) begin
        w_found = 1'b1;
        w_grant = w_cand;
      end
    end
  end

  assign w_accept = bus.rsp_ready[r_owner];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (w_accept) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= GRANT_W'(NUM_REQ - 1);
      r_owner      <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= 1'b0;
      r_result     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_found) begin
        r_owner <= w_grant;
        r_a     <= w_a_arr[w_grant];
        r_b     <= w_b_arr[w_grant];
        r_op    <= bus.req_op[w_grant];
      end
      if (r_state == S_EXEC) r_result <= bus.alu_c;
      if (r_state == S_RESP && w_accept) r_last_grant <= r_owner;
    end
  end

  // req_ready is qualified by rst_n so no grant is offered while reset is held.
  assign bus.req_ready = (rst_n && r_state == S_IDLE && w_found) ? (NUM_REQ'(1) << w_grant) : '0;
  assign bus.rsp_valid = (r_state == S_RESP) ? (NUM_REQ'(1) << r_owner) : '0;
  assign bus.rsp_data  = r_result;
  assign bus.alu_a     = r_a;
  assign bus.alu_b     = r_b;
  assign bus.alu_op    = r_op;
  assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed and randomized bench for alu_arbiter against a transaction-level model
module tb_alu_arbiter;
  localparam int WS   = 9;
  localparam int NR   = 4;
  localparam int GW   = $clog2(NR);
  localparam int AW   = NR * WS;
  localparam int MOD  = 1 << WS;
  localparam int MASK = MOD - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WORD_SIZE(WS), .NUM_REQ(NR)) bus ();
  alu_arbiter #(.WORD_SIZE(WS), .NUM_REQ(NR)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Shared ALU seen by the arbiter.
  assign bus.alu_c = bus.alu_op ? (bus.alu_a - bus.alu_b) : (bus.alu_a + bus.alu_b);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Transaction model: phase 0 waiting for a grant, 1 operation in the ALU, 2 response offered.
  int            cyc = 0;
  int            m_phase = 0;
  int            m_last = NR - 1;
  int            m_owner = 0;
  int            m_res = 0;
  int            m_g;
  logic [GW-1:0] m_idx;
  logic [WS-1:0] m_a, m_b;
  logic          m_op;
  logic [NR-1:0] m_er, m_ev;
  logic [NR-1:0] hs_ready = '0;
  int            grant_q[$], gcyc_q[$], acc_q[$], acyc_q[$];

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      m_phase  = 0;
      m_last   = NR - 1;
      hs_ready = '0;
    end else begin
      m_er = '0;
      m_g  = -1;
      if (m_phase == 0) begin
        for (int k = 1; k <= NR; k++) begin
          m_idx = GW'((m_last + k) % NR);
          if (m_g < 0 && bus.req_valid[m_idx]) m_g = int'(m_idx);
        end
      end
      if (m_g >= 0) m_er = NR'(1 << m_g);
      chk("req_ready", 64'(bus.req_ready), 64'(m_er));
      chk("busy", 64'(bus.busy), 64'(m_phase != 0));
      if (m_phase == 1) begin
        chk("alu_a", 64'(bus.alu_a), 64'(m_a));
        chk("alu_b", 64'(bus.alu_b), 64'(m_b));
        chk("alu_op", 64'(bus.alu_op), 64'(m_op));
      end
      m_ev = (m_phase == 2) ? NR'(1 << m_owner) : '0;
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_ev));
      if (m_phase == 2) chk("rsp_data", 64'(bus.rsp_data), 64'(m_res));
      hs_ready = m_er;
      case (m_phase)
        0: if (m_g >= 0) begin
          m_owner = m_g;
          m_a     = WS'(bus.req_a >> (m_g * WS));
          m_b     = WS'(bus.req_b >> (m_g * WS));
          m_op    = bus.req_op[GW'(m_g)];
          m_res   = m_op ? (int'(m_a) - int'(m_b) + MOD) % MOD : (int'(m_a) + int'(m_b)) % MOD;
          grant_q.push_back(m_g);
          gcyc_q.push_back(cyc);
          m_phase = 1;
        end
        1: m_phase = 2;
        default: if (bus.rsp_ready[GW'(m_owner)]) begin
          acc_q.push_back(int'(bus.rsp_data));
          acyc_q.push_back(cyc);
          m_last  = m_owner;
          m_phase = 0;
        end
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~hs_ready;
  endtask

  task automatic set_req(input int i, input int a, input int b, input int op);
    bus.req_a     = (bus.req_a & ~(AW'(MASK) << (i * WS))) | (AW'(a & MASK) << (i * WS));
    bus.req_b     = (bus.req_b & ~(AW'(MASK) << (i * WS))) | (AW'(b & MASK) << (i * WS));
    bus.req_op    = (bus.req_op & ~NR'(1 << i)) | NR'((op & 1) << i);
    bus.req_valid = bus.req_valid | NR'(1 << i);
  endtask

  task automatic wait_accepts(input int n, input int budget, input string tag);
    int start;
    start = acc_q.size();
    for (int t = 0; t < budget && acc_q.size() < start + n; t++) step();
    if (acc_q.size() < start + n) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    for (int t = 0; t < 20 && m_phase != 0; t++) step();
    step();
    if (m_phase != 0) chk({tag, "_idle_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_op(input int i, input int a, input int b, input int op, input int exp, input string tag);
    int start;
    start = acc_q.size();
    set_req(i, a, b, op);
    wait_accepts(1, 20, tag);
    if (acc_q.size() > start) chk(tag, 64'(acc_q[start]), 64'(exp));
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  int base, abase, ea, eb, eo, d, ok;

  initial begin
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0; bus.rsp_ready = '1;
    repeat (2) @(posedge clk);
    #1;
    bus.req_valid = '1;
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_alu_a", 64'(bus.alu_a), 64'd0);
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    bus.req_valid = '0;
    step();
    rst_n = 1'b1;
    step();

    // Single request with cycle-exact latency.
    set_req(2, 5, 7, 0);
    @(negedge clk); chk("t1_ready", 64'(bus.req_ready), 64'b0100);
    step();
    @(negedge clk); chk("t1_exec_busy", 64'(bus.busy), 64'd1); chk("t1_alu_a", 64'(bus.alu_a), 64'd5);
    step();
    @(negedge clk); chk("t1_rsp_valid", 64'(bus.rsp_valid), 64'b0100); chk("t1_rsp_data", 64'(bus.rsp_data), 64'd12);
    step();
    @(negedge clk); chk("t1_busy_after", 64'(bus.busy), 64'd0);
    step();

    run_op(0, 5, 9, 1, 508, "wrap_sub");
    run_op(1, 511, 1, 0, 0, "wrap_add");
    wait_idle("wrap");

    // Contention from reset: expect 0,1,2,3 three cycles apart.
    pulse_reset();
    base = grant_q.size(); abase = acc_q.size();
    for (int i = 0; i < NR; i++) set_req(i, i * 10 + 1, i * 3 + 2, i % 2);
    wait_accepts(4, 40, "contend");
    if (acc_q.size() >= abase + 4) begin
      for (int i = 0; i < NR; i++) begin
        ea = i * 10 + 1; eb = i * 3 + 2; eo = i % 2;
        chk($sformatf("contend_grant%0d", i), 64'(grant_q[base + i]), 64'(i));
        chk($sformatf("contend_res%0d", i), 64'(acc_q[abase + i]), 64'(eo ? (ea - eb + MOD) % MOD : (ea + eb) % MOD));
        if (i > 0) chk($sformatf("contend_gap%0d", i), 64'(gcyc_q[base + i] - gcyc_q[base + i - 1]), 64'd3);
      end
    end
    wait_idle("contend");

    // Fairness: 0 and 3 requesting continuously.
    base = grant_q.size();
    for (int t = 0; t < 60 && grant_q.size() < base + 8; t++) begin
      step();
      if (!bus.req_valid[0]) set_req(0, $urandom_range(MASK), $urandom_range(MASK), $urandom_range(1));
      if (!bus.req_valid[3]) set_req(3, $urandom_range(MASK), $urandom_range(MASK), $urandom_range(1));
    end
    if (grant_q.size() < base + 8) chk("fair_timeout", 64'd0, 64'd1);
    else for (int k = 0; k < 8; k++) chk($sformatf("fair_grant%0d", k), 64'(grant_q[base + k]), 64'((k % 2) ? 3 : 0));
    wait_idle("fair");

    // Backpressure on requester 1 with requester 2 waiting.
    base = grant_q.size(); abase = acc_q.size();
    bus.rsp_ready = '0;
    set_req(1, 100, 23, 0);
    set_req(2, 40, 50, 1);
    ok = 0;
    for (int t = 0; t < 10 && ok == 0; t++) begin
      step();
      @(negedge clk);
      if (bus.rsp_valid != '0) ok = 1;
    end
    chk("bp_reached", 64'(ok), 64'd1);
    d = int'(bus.rsp_data);
    chk("bp_data", 64'(d), 64'd123);
    for (int t = 0; t < 5; t++) begin
      step();
      @(negedge clk);
      chk("bp_hold_valid", 64'(bus.rsp_valid), 64'b0010);
      chk("bp_hold_data", 64'(bus.rsp_data), 64'(d));
      chk("bp_hold_ready", 64'(bus.req_ready), 64'd0);
    end
    step();
    bus.rsp_ready = '1;
    wait_accepts(2, 20, "bp");
    if (acc_q.size() >= abase + 2) begin
      chk("bp_second_grant", 64'(grant_q[base + 1]), 64'd2);
      chk("bp_order", 64'(gcyc_q[base + 1]), 64'(acyc_q[abase] + 1));
      chk("bp_second_res", 64'(acc_q[abase + 1]), 64'(502));
    end
    wait_idle("bp");

    // Reset during EXEC.
    set_req(2, 77, 33, 1);
    for (int t = 0; t < 10 && m_phase != 1; t++) step();
    chk("mid_exec_reached", 64'(m_phase), 64'd1);
    set_req(0, 1, 2, 0);
    set_req(3, 3, 4, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(bus.req_ready), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid_rst_alu_a", 64'(bus.alu_a), 64'd0);
    chk("mid_rst_alu_b", 64'(bus.alu_b), 64'd0);
    chk("mid_rst_alu_op", 64'(bus.alu_op), 64'd0);
    chk("mid_rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    step();
    rst_n = 1'b1;
    base = grant_q.size();
    for (int t = 0; t < 10 && grant_q.size() == base; t++) step();
    if (grant_q.size() == base) chk("mid_rst_grant_timeout", 64'd0, 64'd1);
    else chk("mid_rst_prio", 64'(grant_q[base]), 64'd0);
    wait_idle("mid_rst");

    // Randomized traffic with random backpressure and abandoned requests.
    for (int t = 0; t < 400; t++) begin
      step();
      for (int i = 0; i < NR; i++) begin
        if (!bus.req_valid[GW'(i)]) begin
          if ($urandom_range(99) < 30) set_req(i, $urandom_range(MASK), $urandom_range(MASK), $urandom_range(1));
        end else if ($urandom_range(99) < 3) begin
          bus.req_valid = bus.req_valid & ~NR'(1 << i);
        end
      end
      bus.rsp_ready = NR'($urandom);
    end
    wait_idle("random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
